rv32i_exec_unit: RTL and testbench

Single-cycle RV32I decode/execute/memory-control unit with an integrated 32×32 register file. It is everything in the core except the PC register and the memories. Each cycle it decodes the instruction presented by fetch, computes the ALU result, drives the data-memory request and the next PC, and writes the result back to the register file on the clock edge. The owning CPU holds the PC register, loads `next_pc` every cycle and feeds back `pc`/`instruction`.

---
 rtl/rv32i_exec_unit.sv | 217 +++++++++++++++++++++
 tb/tb_rv32i_exec_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_exec_unit.sv
// rtl/rv32i_exec_unit.sv - single-cycle RV32I decode/execute/memory-control unit with register file
//
// Everything in the core except the PC register and the memories. Each cycle the
// instruction at i_pc is decoded and executed combinationally. The result is
// written back to the register file on the rising edge of i_clock.
//
// Ports:
//   i_clock         sole clock, all state updates on the rising edge
//   i_reset_n       asynchronous active-low reset, clears x1..x31
//   i_pc            address of the current instruction
//   i_instruction   current instruction word
//   i_read_data     load data, right-justified, returned combinationally
//   o_next_pc       PC for the next cycle
//   o_address       data-memory byte address (always the ALU result)
//   o_read_enable   high for legal loads
//   o_write_data    rs2 value, right-justified
//   o_write_enable  high for legal stores
//   o_write_wstrb   access width: 0=byte, 1=half, 2=word, 3=no access
//   o_illegal_instr instruction outside the supported RV32I subset
//   o_debug_ebreak  instruction is EBREAK
//   o_debug_reg     register file contents, x<i> at bits [32*i +: 32]

module rv32i_exec_unit (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_instruction,
  input  logic [31:0]   i_read_data,
  output logic [31:0]   o_next_pc,
  output logic [31:0]   o_address,
  output logic          o_read_enable,
  output logic [31:0]   o_write_data,
  output logic          o_write_enable,
  output logic [1:0]    o_write_wstrb,
  output logic          o_illegal_instr,
  output logic          o_debug_ebreak,
  output logic [1023:0] o_debug_reg
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // r_regs[0] is reset to zero and never written, so x0 reads as 0 with no read mux.
  logic [31:0] r_regs [0:31];

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;

  assign w_opcode  = i_instruction[6:0];
  assign w_rd      = i_instruction[11:7];
  assign w_funct3  = i_instruction[14:12];
  assign w_rs1     = i_instruction[19:15];
  assign w_rs2     = i_instruction[24:20];
  assign w_funct7  = i_instruction[31:25];
  assign w_rs1_val = r_regs[w_rs1];
  assign w_rs2_val = r_regs[w_rs2];

  assign w_imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
  assign w_imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign w_imm_b = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                    i_instruction[30:25], i_instruction[11:8], 1'b0};
  assign w_imm_j = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                    i_instruction[20], i_instruction[30:21], 1'b0};
  assign w_imm_u = {i_instruction[31:12], 12'b0};

  logic        w_legal, w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_rf_we;
  logic [31:0] w_op1, w_op2;
  logic [2:0]  w_alu_sel;
  logic        w_alu_alt;

  // Decode: legality, operand selection and ALU function. Non-OP/OP-IMM
  // instructions use ALU function 0 (add) for address/target computation.
  always_comb begin
    w_legal     = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    w_rf_we     = 1'b0;
    w_op1       = w_rs1_val;
    w_op2       = w_rs2_val;
    w_alu_sel   = 3'd0;
    w_alu_alt   = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_legal = 1'b1; w_rf_we = 1'b1; w_op1 = 32'd0; w_op2 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1; w_rf_we = 1'b1; w_op1 = i_pc; w_op2 = w_imm_u;
      end
      OPC_JAL: begin
        w_legal = 1'b1; w_rf_we = 1'b1; w_is_jal = 1'b1;
      end
      OPC_JALR: begin
        w_legal = (w_funct3 == 3'd0); w_rf_we = 1'b1; w_is_jalr = 1'b1; w_op2 = w_imm_i;
      end
      OPC_BRANCH: begin
        w_legal = (w_funct3 != 3'd2) && (w_funct3 != 3'd3); w_is_branch = 1'b1;
      end
      OPC_LOAD: begin
        w_legal = (w_funct3 != 3'd3) && (w_funct3 != 3'd6) && (w_funct3 != 3'd7);
        w_is_load = 1'b1; w_rf_we = 1'b1; w_op2 = w_imm_i;
      end
      OPC_STORE: begin
        w_legal = (w_funct3 <= 3'd2); w_is_store = 1'b1; w_op2 = w_imm_s;
      end
      OPC_OPIMM: begin
        w_op2 = w_imm_i; w_alu_sel = w_funct3; w_rf_we = 1'b1;
        // instr[30] is only an opcode bit for the right shifts; elsewhere it is immediate.
        w_alu_alt = (w_funct3 == 3'd5) && i_instruction[30];
        if (w_funct3 == 3'd1)      w_legal = (w_funct7 == 7'h00);
        else if (w_funct3 == 3'd5) w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
        else                       w_legal = 1'b1;
      end
      OPC_OP: begin
        w_alu_sel = w_funct3; w_alu_alt = i_instruction[30]; w_rf_we = 1'b1;
        w_legal = (w_funct7 == 7'h00) ||
                  ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)));
      end
      OPC_FENCE:  w_legal = (w_funct3 == 3'd0);
      OPC_SYSTEM: w_legal = (i_instruction == 32'h00000073) || (i_instruction == 32'h00100073);
      default:    w_legal = 1'b0;
    endcase
  end

  logic w_taken;
  always_comb begin
    case (w_funct3)
      3'd0:    w_taken = (w_rs1_val == w_rs2_val);
      3'd1:    w_taken = (w_rs1_val != w_rs2_val);
      3'd4:    w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'd5:    w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'd6:    w_taken = (w_rs1_val <  w_rs2_val);
      3'd7:    w_taken = (w_rs1_val >= w_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  logic [31:0] w_alu_result;
  always_comb begin
    case (w_alu_sel)
      3'd0:    w_alu_result = w_alu_alt ? (w_op1 - w_op2) : (w_op1 + w_op2);
      3'd1:    w_alu_result = w_op1 << w_op2[4:0];
      3'd2:    w_alu_result = {31'd0, $signed(w_op1) < $signed(w_op2)};
      3'd3:    w_alu_result = {31'd0, w_op1 < w_op2};
      3'd4:    w_alu_result = w_op1 ^ w_op2;
      3'd5:    w_alu_result = w_alu_alt ? $unsigned($signed(w_op1) >>> w_op2[4:0])
                                        : (w_op1 >> w_op2[4:0]);
      3'd6:    w_alu_result = w_op1 | w_op2;
      default: w_alu_result = w_op1 & w_op2;
    endcase
    if (w_is_branch) w_alu_result = {31'd0, w_taken};
  end

  logic [31:0] w_load_val;
  always_comb begin
    case (w_funct3)
      3'd0:    w_load_val = {{24{i_read_data[7]}}, i_read_data[7:0]};
      3'd1:    w_load_val = {{16{i_read_data[15]}}, i_read_data[15:0]};
      3'd4:    w_load_val = {24'd0, i_read_data[7:0]};
      3'd5:    w_load_val = {16'd0, i_read_data[15:0]};
      default: w_load_val = i_read_data;
    endcase
  end

  logic [31:0] w_pc_plus4, w_wb_data;
  assign w_pc_plus4 = i_pc + 32'd4;
  assign w_wb_data  = (w_is_jal || w_is_jalr) ? w_pc_plus4 :
                      w_is_load               ? w_load_val : w_alu_result;

  always_comb begin
    o_next_pc = w_pc_plus4;
    if (w_legal) begin
      if (w_is_branch && w_taken) o_next_pc = i_pc + w_imm_b;
      else if (w_is_jal)          o_next_pc = i_pc + w_imm_j;
      else if (w_is_jalr)         o_next_pc = w_alu_result & ~32'd1;
    end
  end

  assign o_address       = w_alu_result;
  assign o_read_enable   = w_legal && w_is_load;
  assign o_write_enable  = w_legal && w_is_store;
  assign o_write_wstrb   = (o_read_enable || o_write_enable) ? w_funct3[1:0] : 2'd3;
  assign o_write_data    = w_rs2_val;
  assign o_illegal_instr = !w_legal;
  assign o_debug_ebreak  = (i_instruction == 32'h00100073);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_legal && w_rf_we && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= w_wb_data;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 32; g++) begin : g_dbg
      assign o_debug_reg[32*g +: 32] = r_regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// tb/tb_rv32i_exec_unit.sv - self-checking bench for rv32i_exec_unit against an ISA-level model

module tb_rv32i_exec_unit;

  logic          clk;
  logic          i_reset_n;
  logic [31:0]   i_pc, i_instruction, i_read_data;
  logic [31:0]   o_next_pc, o_address, o_write_data;
  logic          o_read_enable, o_write_enable, o_illegal_instr, o_debug_ebreak;
  logic [1:0]    o_write_wstrb;
  logic [1023:0] o_debug_reg;

  rv32i_exec_unit dut (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_pc(i_pc), .i_instruction(i_instruction),
    .i_read_data(i_read_data), .o_next_pc(o_next_pc), .o_address(o_address),
    .o_read_enable(o_read_enable), .o_write_data(o_write_data),
    .o_write_enable(o_write_enable), .o_write_wstrb(o_write_wstrb),
    .o_illegal_instr(o_illegal_instr), .o_debug_ebreak(o_debug_ebreak),
    .o_debug_reg(o_debug_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] npc, addr, wdata, wval;
    logic        re, we, ill, ebk, wen;
    logic [1:0]  wstrb;
    logic [4:0]  rd;
  } exp_t;

  logic [31:0] m_regs [0:31];
  exp_t        e;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // Arithmetic of one OP/OP-IMM mnemonic, chosen by funct3 and the alternate bit.
  function automatic logic [31:0] arith(logic [2:0] f3, logic alt, logic [31:0] x, logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x; sy = y;
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return (sx < sy) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: if (alt) return sx >>> y[4:0]; else return x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc, logic [31:0] rdat);
    exp_t r;
    logic [31:0] a, b, ii, is, ib, ij, iu;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        tk;
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    iu = {ins[31:12], 12'd0};
    r.npc = pc + 32'd4; r.addr = 32'd0; r.wdata = b; r.wval = 32'd0;
    r.re = 1'b0; r.we = 1'b0; r.ill = 1'b0; r.wen = 1'b0; r.wstrb = 2'd3;
    r.ebk = (ins == 32'h00100073); r.rd = ins[11:7];
    case (ins[6:0])
      7'h37: begin r.wen = 1'b1; r.wval = iu; end
      7'h17: begin r.wen = 1'b1; r.wval = pc + iu; end
      7'h6f: begin r.wen = 1'b1; r.wval = pc + 32'd4; r.npc = pc + ij; end
      7'h67: if (f3 == 3'd0) begin r.wen = 1'b1; r.wval = pc + 32'd4; r.npc = (a + ii) & ~32'd1; end
             else r.ill = 1'b1;
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: begin tk = 1'b0; r.ill = 1'b1; end
        endcase
        if (tk) r.npc = pc + ib;
      end
      7'h03: begin
        r.addr = a + ii;
        case (f3)
          3'd0: r.wval = {{24{rdat[7]}}, rdat[7:0]};
          3'd1: r.wval = {{16{rdat[15]}}, rdat[15:0]};
          3'd2: r.wval = rdat;
          3'd4: r.wval = {24'd0, rdat[7:0]};
          3'd5: r.wval = {16'd0, rdat[15:0]};
          default: r.ill = 1'b1;
        endcase
        r.re = 1'b1; r.wen = 1'b1; r.wstrb = f3[1:0];
      end
      7'h23: begin
        r.addr = a + is;
        if (f3 <= 3'd2) begin r.we = 1'b1; r.wstrb = f3[1:0]; end else r.ill = 1'b1;
      end
      7'h13: begin
        if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) r.ill = 1'b1;
        r.wen = 1'b1; r.wval = arith(f3, (f3 == 3'd5) && ins[30], a, ii);
      end
      7'h33: begin
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) r.ill = 1'b1;
        r.wen = 1'b1; r.wval = arith(f3, ins[30], a, b);
      end
      7'h0f: r.ill = (f3 != 3'd0);
      7'h73: r.ill = !(ins == 32'h00000073 || ins == 32'h00100073);
      default: r.ill = 1'b1;
    endcase
    if (r.ill) begin
      r.wen = 1'b0; r.re = 1'b0; r.we = 1'b0; r.wstrb = 2'd3; r.npc = pc + 32'd4;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_regs(input string tag);
    logic [1023:0] expv;
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      expv[32*i +: 32] = m_regs[i];
      if (o_debug_reg[32*i +: 32] !== m_regs[i]) idx = i;
    end
    n_vec++;
    assert (o_debug_reg === expv) else begin
      n_fail++;
      $error("FAIL %s x%0d observed=%h expected=%h", tag, idx, o_debug_reg[32*idx +: 32], m_regs[idx]);
    end
  endtask

  // Drive one instruction mid-cycle and check every combinational output.
  task automatic present(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rdat);
    @(negedge clk);
    i_instruction = ins; i_pc = pc; i_read_data = rdat;
    #1;
    e = model(ins, pc, rdat);
    chk("next_pc", o_next_pc, e.npc);
    chk("illegal", {31'd0, o_illegal_instr}, {31'd0, e.ill});
    chk("ebreak", {31'd0, o_debug_ebreak}, {31'd0, e.ebk});
    chk("read_en", {31'd0, o_read_enable}, {31'd0, e.re});
    chk("write_en", {31'd0, o_write_enable}, {31'd0, e.we});
    chk("wstrb", {30'd0, o_write_wstrb}, {30'd0, e.wstrb});
    if (e.re || e.we) chk("address", o_address, e.addr);
    if (e.we) chk("write_data", o_write_data, e.wdata);
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (i_reset_n && e.wen && e.rd != 5'd0) m_regs[e.rd] = e.wval;
    chk_regs("regfile");
  endtask

  task automatic exec(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rdat);
    present(ins, pc, rdat);
    commit();
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [11:0] imm;
    logic [6:0] f7;
    logic [31:0] w;
    k = $urandom_range(0, 12);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom); imm = 12'($urandom); w = $urandom;
    case (k)
      0, 1: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = w[0] ? 7'h20 : 7'h00;
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      2, 3: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && w[1]) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd);
      end
      4:  return enc_u(w[19:0], rd, w[20] ? 7'h37 : 7'h17);
      5:  return enc_j(w[20:0], rd);
      6:  return enc_i(imm, rs1, 3'd0, rd, 7'h67);
      7:  return enc_b(w[12:0], rs2, rs1, f3);
      8:  return enc_i(imm, rs1, f3, rd, 7'h03);
      9:  return enc_s(imm, rs2, rs1, f3);
      10: return w;
      11: case (w[1:0])
            2'd0: return 32'h00000073;
            2'd1: return 32'h00100073;
            2'd2: return 32'h0ff0000f;
            default: return 32'h00001073;
          endcase
      default: return enc_r(7'($urandom), rs2, rs1, f3, rd);
    endcase
  endfunction

  initial begin
    i_reset_n = 1'b0; i_pc = 32'd0; i_instruction = 32'h00000013; i_read_data = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    e = model(32'h00000013, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset_state");
    @(negedge clk);
    i_reset_n = 1'b1;

    exec(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0, 32'h0);
    exec(enc_i(12'hffd, 5'd0, 3'd0, 5'd2, 7'h13), 32'h4, 32'h0);
    exec(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h8, 32'h0);
    exec(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 32'hc, 32'h0);
    chk("add_x3", o_debug_reg[3*32 +: 32], 32'd2);
    chk("sub_x4", o_debug_reg[4*32 +: 32], 32'd8);

    exec(enc_u(20'h80000, 5'd5, 7'h37), 32'h10, 32'h0);
    exec(enc_i({7'h20, 5'd4}, 5'd5, 3'd5, 5'd6, 7'h13), 32'h14, 32'h0);
    chk("srai", o_debug_reg[6*32 +: 32], 32'hF8000000);
    exec(enc_i(12'd4, 5'd5, 3'd5, 5'd7, 7'h13), 32'h18, 32'h0);
    chk("srli", o_debug_reg[7*32 +: 32], 32'h08000000);
    exec(enc_i(12'hfff, 5'd0, 3'd0, 5'd8, 7'h13), 32'h1c, 32'h0);
    exec(enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13), 32'h20, 32'h0);
    exec(enc_r(7'h00, 5'd9, 5'd8, 3'd2, 5'd10), 32'h24, 32'h0);
    chk("slt", o_debug_reg[10*32 +: 32], 32'd1);
    exec(enc_r(7'h00, 5'd9, 5'd8, 3'd3, 5'd11), 32'h28, 32'h0);
    chk("sltu", o_debug_reg[11*32 +: 32], 32'd0);
    exec(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13), 32'h2c, 32'h0);
    chk("x0_zero", o_debug_reg[31:0], 32'd0);

    exec(enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13), 32'h30, 32'h0);
    present(enc_s(12'd8, 5'd2, 5'd1, 3'd2), 32'h34, 32'h0);
    chk("sw_addr", o_address, 32'h108);
    chk("sw_wstrb", {30'd0, o_write_wstrb}, 32'd2);
    chk("sw_data", o_write_data, 32'hFFFFFFFD);
    commit();
    present(enc_s(12'd0, 5'd2, 5'd1, 3'd0), 32'h38, 32'h0);
    chk("sb_wstrb", {30'd0, o_write_wstrb}, 32'd0);
    commit();
    present(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd16), 32'h3c, 32'h0);
    chk("add_wstrb", {30'd0, o_write_wstrb}, 32'd3);
    commit();

    exec(enc_i(12'd0, 5'd1, 3'd0, 5'd12, 7'h03), 32'h40, 32'h000000F0);
    chk("lb", o_debug_reg[12*32 +: 32], 32'hFFFFFFF0);
    exec(enc_i(12'd0, 5'd1, 3'd4, 5'd13, 7'h03), 32'h44, 32'h000000F0);
    chk("lbu", o_debug_reg[13*32 +: 32], 32'h000000F0);
    exec(enc_i(12'd0, 5'd1, 3'd1, 5'd14, 7'h03), 32'h48, 32'h00008001);
    chk("lh", o_debug_reg[14*32 +: 32], 32'hFFFF8001);
    present(enc_i(12'd0, 5'd1, 3'd2, 5'd15, 7'h03), 32'h4c, 32'h00008001);
    chk("lw_re", {31'd0, o_read_enable}, 32'd1);
    commit();
    chk("lw", o_debug_reg[15*32 +: 32], 32'h00008001);

    present(enc_b(13'h10, 5'd1, 5'd1, 3'd0), 32'h40, 32'h0);
    chk("beq_taken", o_next_pc, 32'h50);
    commit();
    present(enc_b(13'h10, 5'd1, 5'd1, 3'd1), 32'h40, 32'h0);
    chk("bne_not", o_next_pc, 32'h44);
    commit();
    present(enc_b(13'h10, 5'd8, 5'd9, 3'd6), 32'h40, 32'h0);
    chk("bltu_taken", o_next_pc, 32'h50);
    commit();
    present(enc_j(21'h1FFFF8, 5'd1), 32'h40, 32'h0);
    chk("jal_pc", o_next_pc, 32'h38);
    commit();
    chk("jal_link", o_debug_reg[1*32 +: 32], 32'h44);
    exec(enc_i(12'h100, 5'd0, 3'd0, 5'd2, 7'h13), 32'h44, 32'h0);
    present(enc_i(12'd3, 5'd2, 3'd0, 5'd1, 7'h67), 32'h48, 32'h0);
    chk("jalr_pc", o_next_pc, 32'h102);
    commit();

    present(32'h00100073, 32'h60, 32'h0);
    chk("ebreak_flag", {31'd0, o_debug_ebreak}, 32'd1);
    chk("ebreak_legal", {31'd0, o_illegal_instr}, 32'd0);
    commit();
    present(32'hFFFFFFFF, 32'h64, 32'h0);
    chk("illegal_flag", {31'd0, o_illegal_instr}, 32'd1);
    chk("illegal_npc", o_next_pc, 32'h68);
    commit();

    // Asynchronous reset asserted mid-cycle, held across an edge, released mid-cycle.
    present(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h70, 32'h0);
    #2;
    i_reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    chk_regs("async_reset");
    commit();
    @(negedge clk);
    i_reset_n = 1'b1;
    exec(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h74, 32'h0);
    chk("post_reset_wb", o_debug_reg[1*32 +: 32], 32'd5);

    for (int n = 0; n < 400; n++) begin
      exec(rand_instr(), $urandom & 32'hFFFFFFFC, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
